// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for a multicycle MIPS core with one unified memory port.
// Decodes op/funct, steps each instruction to writeback and stalls on mem_ready.
module multicycle_control_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC += 4 (waits on mem_ready)
  // DECODE   | register read, branch target into ALUOut
  // MEMADR   | effective address for lw/sw
  // MEMREAD  | data read at ALUOut (waits on mem_ready)
  // MEMWB    | load data into rt
  // MEMWRITE | store to ALUOut (waits on mem_ready)
  // EXECUTE  | R-type ALU operation
  // ALUWB    | R-type result into rd
  // BRANCH   | beq compare, PC <- target when equal
  // ADDIEXEC | reg A + immediate
  // ADDIWB   | addi result into rt
  // JUMP     | PC <- jump target
  // HALT     | illegal opcode trap, left only by reset
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pc_write;
  logic             branch;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_write    = 1'b0;
    branch      = 1'b0;
    ir_write    = 1'b0;
    i_or_d      = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    pc_src      = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (op == OP_SW)      state_d = S_MEMWRITE;
        else if (op == OP_LW) state_d = S_MEMREAD;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD: begin
        i_or_d  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        case (funct)
          6'b100000: alu_control = ALU_ADD;
          6'b100010: alu_control = ALU_SUB;
          6'b100100: alu_control = ALU_AND;
          6'b100101: alu_control = ALU_OR;
          6'b101010: alu_control = ALU_SLT;
          default:   alu_control = ALU_AND;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        branch      = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    pc_en = pc_write | (branch & zero);
    // An instruction interrupted by reset must not leave any architectural write behind.
    if (reset) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end

    count_d = ir_write ? count_q + CNT_W'(1) : count_q;
  end

  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: vector table, directed corner sequences and
// randomized traffic checked against an instruction-plan reference model.
module tb_multicycle_control_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  op = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_control;
  logic [3:0]  state;
  logic        halted;
  logic [31:0] instr_count;

  logic        n_pc_en, n_ir_write, n_i_or_d, n_mem_write, n_reg_write, n_reg_dst, n_mem_to_reg, n_alu_src_a;
  logic [1:0]  n_alu_src_b, n_pc_src;
  logic [2:0]  n_alu_control;
  logic [3:0]  n_state;
  logic        n_halted;
  logic [2:0]  n_count;

  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b1), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src), .state(state),
    .halted(halted), .instr_count(instr_count)
  );

  // Non-trapping variant with a narrow counter, fed the same stimulus.
  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b0), .CNT_W(3)) dut_nop (
    .clock(clock), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(n_pc_en), .ir_write(n_ir_write), .i_or_d(n_i_or_d), .mem_write(n_mem_write),
    .reg_write(n_reg_write), .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_control(n_alu_control), .pc_src(n_pc_src), .state(n_state),
    .halted(n_halted), .instr_count(n_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
    logic       halted;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         lat;
    int         alu3;
    int         pc_en_n;
    int         rw_n;
    int         mw_n;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          m_state;
  logic [31:0] m_cnt;
  int          m_plan[$];
  ctl_t        snap;
  int          snap_state;
  logic [31:0] snap_cnt;
  int          snap0_state;
  int          snap0_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic ctl_t expect_ctl(input int s, input logic [5:0] f, input logic z,
                                      input logic mr, input logic rst);
    ctl_t e;
    e = '0;
    e.alu = 3'b010;
    case (s)
      0:  begin e.src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
      1:  e.src_b = 2'b11;
      2:  begin e.src_a = 1'b1; e.src_b = 2'b10; end
      3:  e.i_or_d = 1'b1;
      4:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      5:  begin e.i_or_d = 1'b1; e.mem_write = 1'b1; end
      6:  begin e.src_a = 1'b1; e.alu = alu_of(f); end
      7:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
      8:  begin e.src_a = 1'b1; e.alu = 3'b110; e.pc_src = 2'b01; e.pc_en = z; end
      9:  begin e.src_a = 1'b1; e.src_b = 2'b10; end
      10: e.reg_write = 1'b1;
      11: begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
      12: e.halted = 1'b1;
      default: ;
    endcase
    if (rst) begin
      e.pc_en = 1'b0; e.ir_write = 1'b0; e.mem_write = 1'b0; e.reg_write = 1'b0;
    end
    return e;
  endfunction

  // Each fetched instruction is expanded into the list of phases it will visit.
  task automatic load_plan(input logic [5:0] o);
    m_plan.delete();
    m_plan.push_back(1);
    case (o)
      6'b100011: begin m_plan.push_back(2); m_plan.push_back(3); m_plan.push_back(4); end
      6'b101011: begin m_plan.push_back(2); m_plan.push_back(5); end
      6'b000000: begin m_plan.push_back(6); m_plan.push_back(7); end
      6'b000100: m_plan.push_back(8);
      6'b001000: begin m_plan.push_back(9); m_plan.push_back(10); end
      6'b000010: m_plan.push_back(11);
      default:   m_plan.push_back(12);
    endcase
  endtask

  task automatic model_update();
    if (reset) begin
      m_state = 0;
      m_cnt   = 0;
      m_plan.delete();
    end else if (m_state == 12) begin
      m_state = 12;
    end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
      m_state = m_state;
    end else begin
      if (m_state == 0) begin
        m_cnt = m_cnt + 1;
        load_plan(op);
      end
      m_state = (m_plan.size() > 0) ? m_plan.pop_front() : 0;
    end
  endtask

  task automatic cycle();
    ctl_t act, ex;
    @(negedge clock);
    act = {pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
           alu_src_b, alu_control, pc_src, halted};
    ex  = expect_ctl(m_state, funct, zero, mem_ready, reset);
    chk("ctl", 64'(act), 64'(ex));
    chk("state", 64'(state), 64'(m_state));
    chk("count", 64'(instr_count), 64'(m_cnt));
    snap        = act;
    snap_state  = int'(state);
    snap_cnt    = instr_count;
    snap0_state = int'(n_state);
    snap0_cnt   = int'(n_count);
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int   exp_seq[6];
    int   n, pcn, rwn, mwn, alu3;

    vecs[0]  = '{6'b100011, 6'd0,      1'b0, 5, 2, 1, 1, 0};
    vecs[1]  = '{6'b101011, 6'd0,      1'b0, 4, 2, 1, 0, 1};
    vecs[2]  = '{6'b000000, 6'b100000, 1'b0, 4, 2, 1, 1, 0};
    vecs[3]  = '{6'b000000, 6'b100010, 1'b0, 4, 6, 1, 1, 0};
    vecs[4]  = '{6'b000000, 6'b100100, 1'b0, 4, 0, 1, 1, 0};
    vecs[5]  = '{6'b000000, 6'b100101, 1'b0, 4, 1, 1, 1, 0};
    vecs[6]  = '{6'b000000, 6'b101010, 1'b0, 4, 7, 1, 1, 0};
    vecs[7]  = '{6'b000000, 6'b000111, 1'b0, 4, 0, 1, 1, 0};
    vecs[8]  = '{6'b001000, 6'd0,      1'b0, 4, 2, 1, 1, 0};
    vecs[9]  = '{6'b000100, 6'd0,      1'b1, 3, 6, 2, 0, 0};
    vecs[10] = '{6'b000100, 6'd0,      1'b0, 3, 6, 1, 0, 0};
    vecs[11] = '{6'b000010, 6'd0,      1'b0, 3, 2, 2, 0, 0};

    m_state = 0;
    m_cnt   = 0;
    @(posedge clock);
    #1;

    // reset state and lw walk
    mem_ready = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b0;
    do_reset();
    chk("reset_state", 64'(snap_state), 64'd0);
    chk("reset_count", 64'(snap_cnt), 64'd0);
    exp_seq = '{0, 1, 2, 3, 4, 0};
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t1_state", 64'(snap_state), 64'(exp_seq[i]));
      chk("t1_reg_write", 64'(snap.reg_write), 64'(snap_state == 4));
      chk("t1_mem_to_reg", 64'(snap.mem_to_reg), 64'(snap_state == 4));
    end
    chk("t1_count", 64'(snap_cnt), 64'd1);

    // R-type slt
    op = 6'b000000; funct = 6'b101010;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i == 2) begin
        chk("t2_exec_state", 64'(snap_state), 64'd6);
        chk("t2_alu", 64'(snap.alu), 64'b111);
      end
      if (i == 3) begin
        chk("t2_wb_state", 64'(snap_state), 64'd7);
        chk("t2_reg_dst", 64'(snap.reg_dst), 64'd1);
        chk("t2_reg_write", 64'(snap.reg_write), 64'd1);
      end
    end

    // beq taken then not taken
    op = 6'b000100; funct = 6'd0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      for (int i = 0; i < 4; i++) begin
        cycle();
        if (i == 2) begin
          chk("t3_branch_state", 64'(snap_state), 64'd8);
          chk("t3_pc_en", 64'(snap.pc_en), 64'(k == 0));
          chk("t3_pc_src", 64'(snap.pc_src), 64'b01);
        end
        if (i == 3) chk("t3_back_fetch", 64'(snap_state), 64'd0);
      end
      if (k == 0) begin
        reset = 1'b1; cycle(); reset = 1'b0;
      end
    end

    // sw stalled three cycles in MEMWRITE
    op = 6'b101011; zero = 1'b0; mem_ready = 1'b1;
    do_reset();
    mwn = 0;
    for (int i = 0; i < 3; i++) cycle();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_stall_state", 64'(snap_state), 64'd5);
      if (snap.mem_write) mwn++;
    end
    mem_ready = 1'b1;
    cycle();
    if (snap.mem_write) mwn++;
    chk("t4_mem_write_cycles", 64'(mwn), 64'd4);
    cycle();
    chk("t4_fetch", 64'(snap_state), 64'd0);

    // illegal op: trap vs NOP variant, then reset out of HALT
    op = 6'b111111;
    do_reset();
    cycle(); cycle(); cycle();
    chk("t5_halt_state", 64'(snap_state), 64'd12);
    chk("t5_nop_state", 64'(snap0_state), 64'd0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t5_held", 64'(snap_state), 64'd12);
      chk("t5_halted", 64'(snap.halted), 64'd1);
    end
    reset = 1'b1; cycle(); reset = 1'b0;
    cycle();
    chk("t5_reset_state", 64'(snap_state), 64'd0);
    chk("t5_reset_count", 64'(snap_cnt), 64'd0);

    // reset asserted in MEMWB
    op = 6'b100011;
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    reset = 1'b1;
    cycle();
    chk("t6_in_memwb", 64'(snap_state), 64'd4);
    chk("t6_reg_write", 64'(snap.reg_write), 64'd0);
    reset = 1'b0;
    cycle();
    chk("t6_after", 64'(snap_state), 64'd0);

    // counter wrap on the 3-bit variant
    op = 6'b000010;
    do_reset();
    for (int i = 0; i < 28; i++) cycle();
    chk("t7_count", 64'(snap_cnt), 64'd9);
    chk("t7_wrap", 64'(snap0_cnt), 64'd1);

    // vector table
    mem_ready = 1'b1;
    foreach (vecs[v]) begin
      op = vecs[v].op; funct = vecs[v].funct; zero = vecs[v].zero;
      do_reset();
      n = 0; pcn = 0; rwn = 0; mwn = 0; alu3 = -1;
      for (int i = 0; i < 20; i++) begin
        cycle();
        n++;
        if (n > 1 && snap_state == 0) break;
        if (n == 3) alu3 = int'(snap.alu);
        pcn += int'(snap.pc_en);
        rwn += int'(snap.reg_write);
        mwn += int'(snap.mem_write);
      end
      chk("vec_latency", 64'(n - 1), 64'(vecs[v].lat));
      chk("vec_alu", 64'(alu3), 64'(vecs[v].alu3));
      chk("vec_pc_en", 64'(pcn), 64'(vecs[v].pc_en_n));
      chk("vec_reg_write", 64'(rwn), 64'(vecs[v].rw_n));
      chk("vec_mem_write", 64'(mwn), 64'(vecs[v].mw_n));
    end

    // randomized traffic
    begin
      logic [5:0] ops[6];
      logic [5:0] functs[5];
      ops    = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
      functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      do_reset();
      for (int i = 0; i < 3000; i++) begin
        if (m_state == 0) begin
          op    = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 5)];
          funct = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63)) : functs[$urandom_range(0, 4)];
        end
        mem_ready = ($urandom_range(0, 3) != 0);
        zero      = 1'($urandom_range(0, 1));
        reset     = (m_state == 12) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 59) == 0);
        cycle();
      end
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
